// File: rtl/rx_rm_pkg.sv
// Shared types and default geometry for the receive-side resource demapper sequencer.
package rx_rm_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, MAP} rm_state_t;

  typedef enum logic [1:0] {NULL_BIN, PILOT_BIN, DATA_BIN} bin_class_t;

  localparam int NSC_DEF           = 16;
  localparam int NSYM_DEF          = 14;
  localparam int PILOT_SPACING_DEF = 4;
  localparam int PILOT_OFFSET_DEF  = 1;

endpackage

// File: rtl/rx_rm_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a combinational wrap flag.
module rx_rm_wrap_counter #(
  parameter int MAX = 15,
  parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_rm_sequencer.sv
// Frame-aware subcarrier/symbol sequencer: accepts FFT samples, classifies bins,
// and emits registered indices, class flags and symbol/frame-done strobes.
module rx_rm_sequencer
  import rx_rm_pkg::*;
#(
  parameter int NSC           = NSC_DEF,
  parameter int NSYM          = NSYM_DEF,
  parameter int PILOT_SPACING = PILOT_SPACING_DEF,
  parameter int PILOT_OFFSET  = PILOT_OFFSET_DEF,
  parameter int DC_NULL       = 1,
  localparam int SCW          = $clog2(NSC),
  localparam int SYW          = $clog2(NSYM)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic           i_FFT_valid,
  input  logic           i_isc_valid,
  input  logic           i_valid,
  output logic [SCW-1:0] o_sc_index,
  output logic [SYW-1:0] o_sym_index,
  output logic           o_out_valid,
  output logic           o_is_pilot,
  output logic           o_is_data,
  output logic           o_symbol_done,
  output logic           o_frame_done,
  output logic           o_busy,
  output logic           o_overrun
);

  rm_state_t      r_state;
  rm_state_t      w_state_nxt;
  logic           r_frame_gap;
  logic [SCW-1:0] w_sc_cnt;
  logic [SYW-1:0] w_sym_cnt;
  logic           w_sc_wrap;
  logic           w_sym_wrap;
  logic           w_stage_ok;
  logic           w_accept;
  bin_class_t     w_class;

  logic [SCW-1:0] r_sc_index;
  logic [SYW-1:0] r_sym_index;
  logic           r_out_valid;
  logic           r_is_pilot;
  logic           r_is_data;
  logic           r_symbol_done;
  logic           r_frame_done;
  logic           r_overrun;

  function automatic bin_class_t classify(input logic [SCW-1:0] sc);
    if ((DC_NULL != 0) && (sc == '0)) begin
      return NULL_BIN;
    end else if ((sc & SCW'(PILOT_SPACING - 1)) == SCW'(PILOT_OFFSET)) begin
      return PILOT_BIN;
    end else begin
      return DATA_BIN;
    end
  endfunction

  assign w_stage_ok = i_FFT_valid && i_isc_valid;
  // WAIT may accept on entry, except in the single gap cycle right after a frame end.
  assign w_accept   = i_enable && i_valid && w_stage_ok &&
                      ((r_state == MAP) || ((r_state == WAIT) && !r_frame_gap));
  assign w_class    = classify(w_sc_cnt);

  rx_rm_wrap_counter #(.MAX(NSC - 1)) u_sc_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (!i_enable),
    .inc   (w_accept),
    .count (w_sc_cnt),
    .wrap  (w_sc_wrap)
  );

  rx_rm_wrap_counter #(.MAX(NSYM - 1)) u_sym_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (!i_enable),
    .inc   (w_sc_wrap),
    .count (w_sym_cnt),
    .wrap  (w_sym_wrap)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = WAIT;
        WAIT:    if (w_stage_ok) w_state_nxt = MAP;
        MAP:     if (w_sym_wrap) w_state_nxt = WAIT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_enable) begin
      r_sc_index    <= '0;
      r_sym_index   <= '0;
      r_out_valid   <= 1'b0;
      r_is_pilot    <= 1'b0;
      r_is_data     <= 1'b0;
      r_symbol_done <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_gap   <= 1'b0;
    end else begin
      r_out_valid   <= w_accept;
      r_is_pilot    <= w_accept && (w_class == PILOT_BIN);
      r_is_data     <= w_accept && (w_class == DATA_BIN);
      r_symbol_done <= w_sc_wrap;
      r_frame_done  <= w_sym_wrap;
      r_frame_gap   <= w_sym_wrap;
      if (w_accept) begin
        r_sc_index  <= w_sc_cnt;
        r_sym_index <= w_sym_cnt;
      end
      if (i_valid && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_sc_index    = r_sc_index;
  assign o_sym_index   = r_sym_index;
  assign o_out_valid   = r_out_valid;
  assign o_is_pilot    = r_is_pilot;
  assign o_is_data     = r_is_data;
  assign o_symbol_done = r_symbol_done;
  assign o_frame_done  = r_frame_done;
  assign o_overrun     = r_overrun;
  assign o_busy        = (r_state == MAP);

endmodule

// File: tb/tb_rx_rm_sequencer.sv
// Scoreboard bench for rx_rm_sequencer with default geometry (16 bins x 14 symbols).
module tb_rx_rm_sequencer;

  logic       clk = 1'b0;
  logic       i_rst_n, i_enable, i_FFT_valid, i_isc_valid, i_valid;
  logic [3:0] o_sc_index, o_sym_index;
  logic       o_out_valid, o_is_pilot, o_is_data, o_symbol_done, o_frame_done;
  logic       o_busy, o_overrun;

  int errors = 0;
  int checks = 0;
  int n_valid = 0, n_pilot = 0, n_data = 0, n_sd = 0, n_fd = 0;
  int mdl_sc = 0, mdl_sym = 0;
  int saved_fd;
  logic [13:0] q[$];

  rx_rm_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_FFT_valid   (i_FFT_valid),
    .i_isc_valid   (i_isc_valid),
    .i_valid       (i_valid),
    .o_sc_index    (o_sc_index),
    .o_sym_index   (o_sym_index),
    .o_out_valid   (o_out_valid),
    .o_is_pilot    (o_is_pilot),
    .o_is_data     (o_is_data),
    .o_symbol_done (o_symbol_done),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached: simulation time limit hit, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // expected record: {sc[3:0], sym[3:0], pilot, data, symbol_done, frame_done}
  task automatic push_accept();
    logic nul, p, d, sd, fd;
    nul = (mdl_sc == 0);
    p   = !nul && ((mdl_sc % 4) == 1);
    d   = !nul && !p;
    sd  = (mdl_sc == 15);
    fd  = sd && (mdl_sym == 13);
    q.push_back({4'(mdl_sc), 4'(mdl_sym), p, d, sd, fd});
    if (mdl_sc == 15) begin
      mdl_sc  = 0;
      mdl_sym = (mdl_sym == 13) ? 0 : mdl_sym + 1;
    end else begin
      mdl_sc = mdl_sc + 1;
    end
  endtask

  task automatic cyc(input logic v, input logic f, input logic s, input logic en,
                     input logic acc);
    i_valid     = v;
    i_FFT_valid = f;
    i_isc_valid = s;
    i_enable    = en;
    if (acc) push_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_valid = 0; n_pilot = 0; n_data = 0; n_sd = 0; n_fd = 0;
  endtask

  task automatic mdl_reset();
    mdl_sc = 0; mdl_sym = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, int'(o_out_valid), 0);
    chk({tag, "_sc_index"}, int'(o_sc_index), 0);
    chk({tag, "_sym_index"}, int'(o_sym_index), 0);
    chk({tag, "_flags"}, int'({o_is_pilot, o_is_data, o_symbol_done, o_frame_done}), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_overrun"}, int'(o_overrun), 0);
  endtask

  always @(negedge clk) begin
    logic [13:0] act, e;
    if (o_frame_done) n_fd++;
    if (o_symbol_done) n_sd++;
    if (o_out_valid) begin
      n_valid++;
      if (o_is_pilot) n_pilot++;
      if (o_is_data) n_data++;
      act = {o_sc_index, o_sym_index, o_is_pilot, o_is_data, o_symbol_done, o_frame_done};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sample actual={sc=%0d sym=%0d p%b d%b sd%b fd%b} required={sc=%0d sym=%0d p%b d%b sd%b fd%b}",
                   act[13:10], act[9:6], act[3], act[2], act[1], act[0],
                   e[13:10], e[9:6], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [23:0] vp;
    logic [23:0] ip;
    vp = 24'b1011_0111_1101_0110_1110_1011;
    ip = 24'b1111_1011_1110_1111_0111_1101;
    i_rst_n = 1'b0; i_enable = 1'b0; i_FFT_valid = 1'b0; i_isc_valid = 1'b0; i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // full frame, contiguous
    clr_counts();
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 224; i++) cyc(1, 1, 1, 1, 1);
    chk("frame_done_last", int'(o_frame_done), 1);
    chk("busy_after_frame", int'(o_busy), 0);
    cyc(0, 1, 1, 1, 0);
    chk("busy_next_frame", int'(o_busy), 1);
    chk("frame_valid_count", n_valid, 224);
    chk("frame_symdone_count", n_sd, 14);
    chk("frame_framedone_count", n_fd, 1);
    chk("frame_pilot_count", n_pilot, 56);
    chk("frame_data_count", n_data, 154);
    chk("frame_overrun", int'(o_overrun), 0);

    // one symbol classification
    clr_counts();
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 0);
    chk("sym_pilot_count", n_pilot, 4);
    chk("sym_data_count", n_data, 11);
    chk("sym_valid_count", n_valid, 16);
    chk("sym_symdone_count", n_sd, 1);

    // gaps and isc drops
    chk("gap_overrun_before", int'(o_overrun), 0);
    cyc(1, 1, 0, 1, 0);
    chk("gap_overrun_set", int'(o_overrun), 1);
    for (int i = 0; i < 24; i++) cyc(vp[i], 1, ip[i], 1, vp[i] & ip[i]);
    cyc(0, 1, 1, 1, 0);

    // enable drop at sc=7, sym=3
    cyc(0, 1, 1, 0, 0);
    mdl_reset();
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 55; i++) cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 0, 1, 0);
    chk("endrop_overrun_pre", int'(o_overrun), 1);
    cyc(1, 1, 1, 0, 0);
    chk_all_zero("endrop");
    mdl_reset();
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 1);
    chk("reenable_valid", int'(o_out_valid), 1);
    chk("reenable_sc", int'(o_sc_index), 0);
    chk("reenable_sym", int'(o_sym_index), 0);

    // enable dropped on the last bin of a frame
    for (int i = 0; i < 222; i++) cyc(1, 1, 1, 1, 1);
    chk("lastbin_mdl_sc", mdl_sc, 15);
    saved_fd = n_fd;
    cyc(1, 1, 1, 0, 0);
    chk("lastbin_frame_done", int'(o_frame_done), 0);
    chk("lastbin_out_valid", int'(o_out_valid), 0);
    chk("lastbin_busy", int'(o_busy), 0);
    cyc(0, 1, 1, 0, 0);
    chk("lastbin_fd_count", n_fd, saved_fd);
    mdl_reset();

    // reset mid-frame at sc=10, sym=5
    cyc(0, 1, 1, 1, 0);
    for (int i = 0; i < 90; i++) cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 0, 1, 0);
    chk("rst_overrun_pre", int'(o_overrun), 1);
    chk("rst_busy_pre", int'(o_busy), 1);
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    i_rst_n = 1'b1;
    mdl_reset();
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 1);
    chk("rst_restart_sc", int'(o_sc_index), 0);
    chk("rst_restart_sym", int'(o_sym_index), 0);
    cyc(1, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
